// File: rtl/branch_ctrl_unit_pkg.sv
// Shared opcodes, condition codes, flag indices and FSM states for the
// control-flow resolution block.
package branch_ctrl_unit_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_SLL = 4'h4;
  localparam logic [3:0] OP_SRA = 4'h5;
  localparam logic [3:0] OP_ROR = 4'h6;
  localparam logic [3:0] OP_LI  = 4'h7;
  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'h9;
  localparam logic [3:0] OP_LUI = 4'hA;
  localparam logic [3:0] OP_MOV = 4'hB;
  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_NOP = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] CC_NE = 3'b000;
  localparam logic [2:0] CC_EQ = 3'b001;
  localparam logic [2:0] CC_GT = 3'b010;
  localparam logic [2:0] CC_LT = 3'b011;
  localparam logic [2:0] CC_GE = 3'b100;
  localparam logic [2:0] CC_LE = 3'b101;
  localparam logic [2:0] CC_OV = 3'b110;
  localparam logic [2:0] CC_AL = 3'b111;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FLAG_WAIT = 2'd1,
    ST_HALTED    = 2'd2
  } state_t;

  function automatic logic writes_zvn(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic writes_z(input logic [3:0] op);
    return (op == OP_XOR) || (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/branch_ctrl_unit_cond.sv
// Combinational evaluation of a B/BR condition code against {Z,V,N}.
module branch_cond_eval
  import branch_ctrl_unit_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       cond_met
);

  logic z;
  logic v;
  logic n;

  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];
  assign n = flags[FLAG_N];

  always_comb begin
    cond_met = 1'b0;
    case (cond)
      CC_NE:   cond_met = !z;
      CC_EQ:   cond_met = z;
      CC_GT:   cond_met = !z && !n;
      CC_LT:   cond_met = n;
      CC_GE:   cond_met = z || (!z && !n);
      CC_LE:   cond_met = n || z;
      CC_OV:   cond_met = v;
      CC_AL:   cond_met = 1'b1;
      default: cond_met = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_ctrl_unit.sv
// Control-flow resolution: flag register, B/BR resolution with a one-cycle
// flag-hazard stall, PC redirect/flush, halt, and saturating branch counters.
module branch_ctrl_unit
  import branch_ctrl_unit_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [3:0]        id_opcode,
  input  logic [2:0]        id_cond,
  input  logic [8:0]        id_imm9,
  input  logic [ADDR_W-1:0] id_pc_plus2,
  input  logic [ADDR_W-1:0] id_rs_data,
  input  logic              ex_valid,
  input  logic [3:0]        ex_opcode,
  input  logic [2:0]        alu_flags,
  input  logic              stall_ext,
  output logic [2:0]        flags,
  output logic              stall_id,
  output logic              pc_redirect,
  output logic [ADDR_W-1:0] redirect_target,
  output logic              flush_if,
  output logic              halt,
  output logic [CNT_W-1:0]  branch_count,
  output logic [CNT_W-1:0]  taken_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t state;
  state_t state_next;

  logic                     id_is_branch;
  logic                     id_is_hlt;
  logic                     ex_writes_flags;
  logic                     cond_met;
  logic                     resolve;
  logic                     taken;
  logic signed [ADDR_W-1:0] b_offset;
  logic [ADDR_W-1:0]        b_target;

  assign id_is_branch    = id_valid && ((id_opcode == OP_B) || (id_opcode == OP_BR));
  assign id_is_hlt       = id_valid && (id_opcode == OP_HLT);
  assign ex_writes_flags = ex_valid && (writes_zvn(ex_opcode) || writes_z(ex_opcode));

  branch_cond_eval u_cond (
    .cond     (id_cond),
    .flags    (flags),
    .cond_met (cond_met)
  );

  // Word offset scaled to bytes, sign-extended; the add wraps modulo 2^ADDR_W.
  assign b_offset = {{(ADDR_W-10){id_imm9[8]}}, id_imm9, 1'b0};
  assign b_target = id_pc_plus2 + $unsigned(b_offset);

  always_comb begin
    state_next = state;
    stall_id   = 1'b0;
    resolve    = 1'b0;
    if (!rst) begin
      if (stall_ext) begin
        stall_id = 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (id_is_hlt) begin
              state_next = ST_HALTED;
            end else if (id_is_branch) begin
              if (ex_writes_flags) begin
                stall_id   = 1'b1;
                state_next = ST_FLAG_WAIT;
              end else begin
                resolve = 1'b1;
              end
            end
          end
          ST_FLAG_WAIT: begin
            state_next = ST_IDLE;
            if (id_is_hlt) begin
              state_next = ST_HALTED;
            end else if (id_is_branch) begin
              resolve = 1'b1;
            end
          end
          ST_HALTED: begin
            stall_id = 1'b1;
          end
          default: begin
            state_next = ST_IDLE;
          end
        endcase
      end
    end
  end

  assign taken           = resolve && cond_met;
  assign pc_redirect     = taken;
  assign flush_if        = taken;
  assign redirect_target = !taken ? '0 :
                           (id_opcode == OP_BR) ? id_rs_data : b_target;
  assign halt            = (state == ST_HALTED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else if (!stall_ext) begin
      state <= state_next;
    end
  end

  // Flag register and counters share the external-freeze qualifier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags        <= 3'b000;
      branch_count <= '0;
      taken_count  <= '0;
    end else if (!stall_ext) begin
      if (ex_valid) begin
        if (writes_zvn(ex_opcode)) begin
          flags <= alu_flags;
        end else if (writes_z(ex_opcode)) begin
          flags[FLAG_Z] <= alu_flags[FLAG_Z];
        end
      end
      if (resolve) begin
        branch_count <= sat_inc(branch_count);
      end
      if (taken) begin
        taken_count <= sat_inc(taken_count);
      end
    end
  end

endmodule

// File: tb/tb_branch_ctrl_unit.sv
// Randomized and directed bench for branch_ctrl_unit against a behavioural model.
module tb_branch_ctrl_unit;

  localparam int AW  = 16;
  localparam int CW  = 16;
  localparam int SCW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          id_valid;
  logic [3:0]    id_opcode;
  logic [2:0]    id_cond;
  logic [8:0]    id_imm9;
  logic [AW-1:0] id_pc_plus2;
  logic [AW-1:0] id_rs_data;
  logic          ex_valid;
  logic [3:0]    ex_opcode;
  logic [2:0]    alu_flags;
  logic          stall_ext;

  logic [2:0]    flags, s_flags;
  logic          stall_id, s_stall_id;
  logic          pc_redirect, s_pc_redirect;
  logic [AW-1:0] redirect_target, s_redirect_target;
  logic          flush_if, s_flush_if;
  logic          halt, s_halt;
  logic [CW-1:0] branch_count, taken_count;
  logic [SCW-1:0] s_branch_count, s_taken_count;

  branch_ctrl_unit #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_cond(id_cond), .id_imm9(id_imm9), .id_pc_plus2(id_pc_plus2),
    .id_rs_data(id_rs_data), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .alu_flags(alu_flags), .stall_ext(stall_ext), .flags(flags),
    .stall_id(stall_id), .pc_redirect(pc_redirect),
    .redirect_target(redirect_target), .flush_if(flush_if), .halt(halt),
    .branch_count(branch_count), .taken_count(taken_count)
  );

  // Narrow-counter instance so saturation is reached in a short run.
  branch_ctrl_unit #(.ADDR_W(AW), .CNT_W(SCW)) dut_s (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_cond(id_cond), .id_imm9(id_imm9), .id_pc_plus2(id_pc_plus2),
    .id_rs_data(id_rs_data), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .alu_flags(alu_flags), .stall_ext(stall_ext), .flags(s_flags),
    .stall_id(s_stall_id), .pc_redirect(s_pc_redirect),
    .redirect_target(s_redirect_target), .flush_if(s_flush_if), .halt(s_halt),
    .branch_count(s_branch_count), .taken_count(s_taken_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0] m_flags;
  bit         m_wait, m_halt;
  int         m_branches, m_taken;
  bit         e_stall, e_redir, e_resolve;
  logic [AW-1:0] e_tgt;

  function automatic bit cond_true(input logic [2:0] c, input logic [2:0] f);
    bit z = f[2];
    bit v = f[1];
    bit n = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit op_zvn(input logic [3:0] op);
    return op == 4'h0 || op == 4'h1;
  endfunction

  function automatic bit op_z(input logic [3:0] op);
    return op == 4'h2 || op == 4'h4 || op == 4'h5 || op == 4'h6;
  endfunction

  function automatic logic [AW-1:0] b_target(input logic [AW-1:0] pc, input logic [8:0] imm);
    int off = int'(imm);
    if (off >= 256) off -= 512;
    return AW'((int'(pc) + 2 * off + 65536) % 65536);
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_check();
    bit is_br, writer;
    #1;
    e_stall = 0; e_redir = 0; e_resolve = 0; e_tgt = '0;
    if (rst) begin
      m_flags = 3'b000; m_wait = 0; m_halt = 0; m_branches = 0; m_taken = 0;
    end else begin
      is_br  = id_valid && (id_opcode == 4'hC || id_opcode == 4'hD);
      writer = ex_valid && (op_zvn(ex_opcode) || op_z(ex_opcode));
      if (stall_ext || m_halt) e_stall = 1;
      else if (is_br && !m_wait && writer) e_stall = 1;
      else if (is_br) begin
        e_resolve = 1;
        e_redir   = cond_true(id_cond, m_flags);
        if (e_redir) e_tgt = (id_opcode == 4'hD) ? id_rs_data : b_target(id_pc_plus2, id_imm9);
      end
    end
    chk("stall_id", stall_id, e_stall);
    chk("pc_redirect", pc_redirect, e_redir);
    chk("flush_if", flush_if, e_redir);
    chk("redirect_target", redirect_target, e_tgt);
    chk("s_pc_redirect", s_pc_redirect, e_redir);
  endtask

  task automatic advance();
    @(posedge clk);
    if (!rst && !stall_ext) begin
      if (ex_valid) begin
        if (op_zvn(ex_opcode)) m_flags = alu_flags;
        else if (op_z(ex_opcode)) m_flags[2] = alu_flags[2];
      end
      if (e_resolve) begin
        m_branches++;
        if (e_redir) m_taken++;
      end
      if (!m_halt) begin
        if (id_valid && id_opcode == 4'hF) begin
          m_halt = 1; m_wait = 0;
        end else begin
          m_wait = e_stall;
        end
      end
    end
    #1;
    chk("flags", flags, m_flags);
    chk("halt", halt, m_halt);
    chk("branch_count", branch_count, sat(m_branches, 65535));
    chk("taken_count", taken_count, sat(m_taken, 65535));
    chk("s_branch_count", s_branch_count, sat(m_branches, 15));
    chk("s_taken_count", s_taken_count, sat(m_taken, 15));
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_opcode = 4'hE; id_cond = 0; id_imm9 = 0;
    id_pc_plus2 = 0; id_rs_data = 0; ex_valid = 0; ex_opcode = 4'hE;
    alu_flags = 0; stall_ext = 0;
  endtask

  task automatic set_id(input logic [3:0] op, input logic [2:0] c,
                        input logic [8:0] imm, input logic [AW-1:0] pc,
                        input logic [AW-1:0] rs);
    id_valid = 1; id_opcode = op; id_cond = c; id_imm9 = imm;
    id_pc_plus2 = pc; id_rs_data = rs;
  endtask

  task automatic set_ex(input bit v, input logic [3:0] op, input logic [2:0] f);
    ex_valid = v; ex_opcode = op; alu_flags = f;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    @(negedge clk);
    drive_check();
    advance();
    rst = 0;
    chk("reset_flags", flags, 3'b000);
    chk("reset_halt", halt, 1'b0);
    chk("reset_bcount", branch_count, 16'd0);

    // Flag hazard: SUB writes Z in EX while B EQ waits in ID.
    set_ex(1, 4'h1, 3'b100);
    set_id(4'hC, 3'b001, 9'h1FE, 16'h0010, 16'h0);
    drive_check();
    chk("hazard_stall", stall_id, 1'b1);
    chk("hazard_noredir", pc_redirect, 1'b0);
    advance();
    chk("hazard_flags", flags, 3'b100);
    set_ex(0, 4'hE, 3'b000);
    drive_check();
    chk("hazard_redir", pc_redirect, 1'b1);
    chk("hazard_target", redirect_target, 16'h000C);
    chk("hazard_flush", flush_if, 1'b1);
    chk("hazard_nostall", stall_id, 1'b0);
    advance();
    chk("hazard_bcount", branch_count, 16'd1);

    // BR always-taken with a load in EX: no hazard.
    set_ex(1, 4'h8, 3'b000);
    set_id(4'hD, 3'b111, 9'h0, 16'h0, 16'h1234);
    drive_check();
    chk("br_redir", pc_redirect, 1'b1);
    chk("br_target", redirect_target, 16'h1234);
    advance();
    chk("br_taken", taken_count, 16'd2);

    // Partial flag write: XOR only touches Z.
    id_valid = 0;
    set_ex(1, 4'h0, 3'b011);
    drive_check(); advance();
    chk("add_flags", flags, 3'b011);
    set_ex(1, 4'h2, 3'b000);
    drive_check(); advance();
    chk("xor_flags", flags, 3'b011);
    set_ex(0, 4'hE, 3'b000);
    set_id(4'hC, 3'b000, 9'h004, 16'h0040, 16'h0);
    drive_check();
    chk("ne_redir", pc_redirect, 1'b1);
    chk("ne_target", redirect_target, 16'h0048);
    advance();

    // External freeze while waiting on flags.
    set_ex(1, 4'h1, 3'b000);
    set_id(4'hC, 3'b000, 9'h0, 16'h0100, 16'h0);
    drive_check();
    chk("ext_hazard_stall", stall_id, 1'b1);
    advance();
    stall_ext = 1;
    set_ex(1, 4'h1, 3'b100);
    for (int i = 0; i < 3; i++) begin
      drive_check();
      chk("ext_stall", stall_id, 1'b1);
      chk("ext_noredir", pc_redirect, 1'b0);
      advance();
      chk("ext_flags_hold", flags, 3'b000);
    end
    stall_ext = 0;
    set_ex(0, 4'hE, 3'b000);
    drive_check();
    chk("ext_release_redir", pc_redirect, 1'b1);
    chk("ext_release_target", redirect_target, 16'h0100);
    advance();
    chk("ext_bcount", branch_count, 16'd4);
    id_valid = 0;
    drive_check(); advance();
    chk("ext_bcount_once", branch_count, 16'd4);

    // Halt alongside a flag write, then reset out of it.
    set_id(4'hF, 3'b000, 9'h0, 16'h0, 16'h0);
    set_ex(1, 4'h0, 3'b001);
    drive_check(); advance();
    chk("halt_set", halt, 1'b1);
    chk("halt_flags", flags, 3'b001);
    set_ex(0, 4'hE, 3'b000);
    set_id(4'hD, 3'b111, 9'h0, 16'h0, 16'h5555);
    for (int i = 0; i < 10; i++) begin
      drive_check();
      chk("halt_stall", stall_id, 1'b1);
      advance();
      chk("halt_hold", halt, 1'b1);
    end
    rst = 1;
    drive_check();
    chk("rst_stall", stall_id, 1'b0);
    advance();
    chk("rst_halt", halt, 1'b0);
    chk("rst_flags", flags, 3'b000);
    chk("rst_bcount", branch_count, 16'd0);
    chk("rst_tcount", taken_count, 16'd0);
    rst = 0;

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      int r;
      rst = ($urandom_range(0, 59) == 0);
      stall_ext = ($urandom_range(0, 6) == 0);
      ex_valid = $urandom_range(0, 1);
      ex_opcode = 4'($urandom_range(0, 15));
      alu_flags = 3'($urandom_range(0, 7));
      id_valid = ($urandom_range(0, 4) != 0);
      r = $urandom_range(0, 99);
      if (r < 25) id_opcode = 4'hC;
      else if (r < 45) id_opcode = 4'hD;
      else if (r < 47) id_opcode = 4'hF;
      else id_opcode = 4'($urandom_range(0, 14));
      id_cond = 3'($urandom_range(0, 7));
      id_imm9 = 9'($urandom_range(0, 511));
      id_pc_plus2 = 16'($urandom_range(0, 65535));
      id_rs_data = 16'($urandom_range(0, 65535));
      drive_check();
      advance();
    end
    rst = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
